// File: rtl/vc_credit_tx.sv
// Credit-based virtual-channel link transmitter with round-robin VC arbitration.
// Optional sticky credit error flag enabled by defining VC_CREDIT_TX_ERR_CHECK_EN.

package coh_noc_pkg;
    localparam int unsigned FLIT_W = 64;

    typedef struct packed {
        logic [1:0]  kind;
        logic [5:0]  src;
        logic [5:0]  dst;
        logic [49:0] payload;
    } flit_hdr_t;

    typedef union packed {
        flit_hdr_t         hdr;
        logic [FLIT_W-1:0] raw;
    } flit_u;
endpackage

module vc_credit_tx #(
    parameter int unsigned NUM_VC       = 4,
    parameter int unsigned CREDIT_DEPTH = 16,
    localparam int unsigned VC_W        = $clog2(NUM_VC),
    localparam int unsigned CNT_W       = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_VC-1:0]                  in_valid,
    input  coh_noc_pkg::flit_u [NUM_VC-1:0]    in_flit,
    output logic [NUM_VC-1:0]                  in_ready,
    output logic                               out_valid,
    output coh_noc_pkg::flit_u                 out_flit,
    output logic [VC_W-1:0]                    out_vc,
    input  logic                               credit_valid,
    input  logic [VC_W-1:0]                    credit_vc,
    output logic [NUM_VC-1:0][CNT_W-1:0]       credit_cnt,
    output logic                               idle,
    output logic                               credit_err
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CREDIT_DEPTH);

    logic [NUM_VC-1:0][CNT_W-1:0] cnt;
    logic [NUM_VC-1:0][CNT_W-1:0] cnt_nxt;
    logic [VC_W-1:0]              rr_ptr;
    logic [VC_W-1:0]              rr_nxt;
    logic [NUM_VC-1:0]            eligible;
    logic [NUM_VC-1:0]            grant;
    logic [VC_W-1:0]              grant_idx;
    logic                         any_grant;
    logic [NUM_VC-1:0]            cred_hit;
    logic [NUM_VC-1:0]            at_full;

    // Per-VC eligibility, credit return decode and full detection
    always_comb begin
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            eligible[v] = in_valid[v] && (cnt[v] != '0);
            cred_hit[v] = credit_valid && (credit_vc == VC_W'(v));
            at_full[v]  = (cnt[v] == CNT_FULL);
        end
    end

    // Round-robin search starting at rr_ptr
    always_comb begin
        int unsigned idx;
        int unsigned nx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        rr_nxt    = rr_ptr;
        idx       = 0;
        nx        = 0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_VC) begin
                idx = idx - NUM_VC;
            end
            if (!any_grant && eligible[VC_W'(idx)]) begin
                any_grant = 1'b1;
                grant_idx = VC_W'(idx);
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
            nx = 32'(grant_idx) + 1;
            if (nx >= NUM_VC) begin
                nx = 0;
            end
            rr_nxt = VC_W'(nx);
        end
    end

    assign in_ready = rst ? '0 : grant;

    // Simultaneous send and return on one VC cancel out; returns saturate at full
    always_comb begin
        cnt_nxt = cnt;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (grant[v] && !cred_hit[v]) begin
                cnt_nxt[v] = cnt[v] - CNT_W'(1);
            end else if (cred_hit[v] && !grant[v] && !at_full[v]) begin
                cnt_nxt[v] = cnt[v] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VC; v++) begin
                cnt[v] <= CNT_FULL;
            end
            rr_ptr    <= '0;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_vc    <= '0;
        end else begin
            cnt       <= cnt_nxt;
            rr_ptr    <= rr_nxt;
            out_valid <= any_grant;
            if (any_grant) begin
                out_flit <= in_flit[grant_idx];
                out_vc   <= grant_idx;
            end
        end
    end

    assign credit_cnt = cnt;
    assign idle       = (&at_full) && !out_valid;

`ifdef VC_CREDIT_TX_ERR_CHECK_EN
    logic err_set;

    // Overflow: return on a full VC with no send on it, or a return to a nonexistent VC
    assign err_set = (|(cred_hit & at_full & ~grant))
                   || (credit_valid && (32'(credit_vc) >= NUM_VC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_err <= 1'b0;
        end else if (err_set) begin
            credit_err <= 1'b1;
        end
    end
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_vc_credit_tx.sv
// Scoreboard bench for vc_credit_tx: directed stimulus pushes expected link flits,
// a monitor pops and compares them whenever out_valid is seen.

module tb_vc_credit_tx;
    import coh_noc_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [3:0]           in_valid;
    flit_u [3:0]          in_flit;
    logic [3:0]           in_ready;
    logic                 out_valid;
    flit_u                out_flit;
    logic [1:0]           out_vc;
    logic                 credit_valid;
    logic [1:0]           credit_vc;
    logic [3:0][4:0]      credit_cnt;
    logic                 idle;
    logic                 credit_err;

    typedef struct {
        logic [1:0]  vc;
        logic [63:0] raw;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    vc_credit_tx #(.NUM_VC(4), .CREDIT_DEPTH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_flit      (in_flit),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_flit     (out_flit),
        .out_vc       (out_vc),
        .credit_valid (credit_valid),
        .credit_vc    (credit_vc),
        .credit_cnt   (credit_cnt),
        .idle         (idle),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] mk(input int v, input int t);
        return 64'hA5A5_0000_0000_0000 | (64'(v) << 16) | 64'(t);
    endfunction

    task automatic set_flits(input int t);
        for (int v = 0; v < 4; v++) in_flit[v].raw = mk(v, t);
    endtask

    task automatic expect_flit(input int v, input int t);
        exp_t e;
        e.vc  = 2'(v);
        e.raw = mk(v, t);
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        in_valid     = '0;
        credit_valid = 1'b0;
        credit_vc    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic chk_drained(input string name);
        chk(name, 64'(q.size()), 64'd0);
    endtask

    // Monitor: every link flit must match the oldest expected entry
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_flit actual_vc=%0d actual=%0h required=none", out_vc, out_flit.raw);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_vc", 64'(out_vc), 64'(e.vc));
                chk("out_flit", out_flit.raw, e.raw);
            end
        end
    end

    initial begin
        in_flit = '0;
        do_reset();

        // 1: reset state
        repeat (4) step();
        @(negedge clk);
        chk("t1_cnt", 64'(credit_cnt), 64'({4{5'd16}}));
        chk("t1_idle", 64'(idle), 64'd1);
        chk("t1_out_valid", 64'(out_valid), 64'd0);
        chk("t1_in_ready", 64'(in_ready), 64'd0);
        chk("t1_out_flit", out_flit.raw, 64'd0);
        chk("t1_out_vc", 64'(out_vc), 64'd0);
        chk("t1_credit_err", 64'(credit_err), 64'd0);
        step();

        // 2: all VCs pending, round-robin 0,1,2,3,0,1,2,3
        set_flits(2);
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_in_ready", 64'(in_ready), 64'(4'b0001 << (i % 4)));
            expect_flit(i % 4, 2);
            step();
        end
        in_valid = '0;
        step();
        @(negedge clk);
        chk("t2_cnt", 64'(credit_cnt), 64'({4{5'd14}}));
        chk("t2_idle", 64'(idle), 64'd0);
        step();
        chk_drained("t2_drained");

        // 3: drain VC2 credits to zero, one return buys exactly one flit
        do_reset();
        set_flits(3);
        in_valid = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t3_in_ready", 64'(in_ready), (i < 16) ? 64'h4 : 64'h0);
            if (i < 16) expect_flit(2, 3);
            step();
        end
        chk("t3_cnt_zero", 64'(credit_cnt[2]), 64'd0);
        credit_valid = 1'b1;
        credit_vc    = 2'd2;
        @(negedge clk);
        chk("t3_ready_same_cycle", 64'(in_ready), 64'h0);
        step();
        credit_valid = 1'b0;
        chk("t3_cnt_one", 64'(credit_cnt[2]), 64'd1);
        @(negedge clk);
        chk("t3_ready_after_credit", 64'(in_ready), 64'h4);
        expect_flit(2, 3);
        step();
        @(negedge clk);
        chk("t3_ready_zero_again", 64'(in_ready), 64'h0);
        chk("t3_cnt_zero_again", 64'(credit_cnt[2]), 64'd0);
        in_valid = '0;
        step();
        step();
        chk_drained("t3_drained");

        // 4: send and return on VC1 in the same cycle at cnt=5
        do_reset();
        set_flits(4);
        in_valid = 4'b0010;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            expect_flit(1, 4);
            step();
        end
        chk("t4_cnt_five", 64'(credit_cnt[1]), 64'd5);
        credit_valid = 1'b1;
        credit_vc    = 2'd1;
        @(negedge clk);
        chk("t4_in_ready", 64'(in_ready), 64'h2);
        expect_flit(1, 4);
        step();
        credit_valid = 1'b0;
        in_valid     = '0;
        @(negedge clk);
        chk("t4_cnt_held", 64'(credit_cnt[1]), 64'd5);
        chk("t4_out_valid", 64'(out_valid), 64'd1);
        step();
        credit_valid = 1'b1;
        credit_vc    = 2'd1;
        step();
        credit_valid = 1'b0;
        chk("t4_cnt_return", 64'(credit_cnt[1]), 64'd6);
        chk_drained("t4_drained");

        // 5: full VC0 with send+return is no error; a lone return then overflows
        set_flits(5);
        in_valid     = 4'b0001;
        credit_valid = 1'b1;
        credit_vc    = 2'd0;
        @(negedge clk);
        chk("t5_in_ready", 64'(in_ready), 64'h1);
        expect_flit(0, 5);
        step();
        in_valid     = '0;
        credit_valid = 1'b0;
        @(negedge clk);
        chk("t5_cnt_both", 64'(credit_cnt[0]), 64'd16);
        chk("t5_err_both", 64'(credit_err), 64'd0);
        step();
        credit_valid = 1'b1;
        credit_vc    = 2'd0;
        step();
        credit_valid = 1'b0;
        @(negedge clk);
        chk("t5_cnt_sat", 64'(credit_cnt[0]), 64'd16);
`ifdef VC_CREDIT_TX_ERR_CHECK_EN
        chk("t5_err_ovf", 64'(credit_err), 64'd1);
`else
        chk("t5_err_ovf", 64'(credit_err), 64'd0);
`endif
        step();
        chk_drained("t5_drained");

        // 6: reset with a flit in flight
        do_reset();
        set_flits(6);
        in_valid = 4'b0011;
        @(negedge clk);
        chk("t6_in_ready_first", 64'(in_ready), 64'h1);
        expect_flit(0, 6);
        step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_out_valid_rst", 64'(out_valid), 64'd0);
        chk("t6_out_flit_rst", out_flit.raw, 64'd0);
        chk("t6_in_ready_rst", 64'(in_ready), 64'd0);
        chk("t6_cnt_rst", 64'(credit_cnt), 64'({4{5'd16}}));
        chk("t6_idle_rst", 64'(idle), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rr_restart", 64'(in_ready), 64'h1);
        expect_flit(0, 6);
        step();
        in_valid = '0;
        step();
        step();
        chk_drained("t6_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
